// File: rtl/blink_dec_iter_pkg.sv
// Shared definitions for the round-serial Blink-64 decrypt engine.
// Holds the block/round parameters, the round-constant words, the FSM state
// type and the cipher primitives (cell substitution, column mixing, round
// functions and the tweak hash). The primitives are pure functions, so every
// user gets identical combinational logic.
package blink_dec_iter_pkg;

    localparam int ROUNDS = 14;
    localparam int R1     = 3;
    localparam int BLK    = 64;
    localparam int KEY_W  = 448;
    localparam int K1_W   = 254;

    // Eight 128-bit words each; word m sits at bits [128m+127:128m].
    localparam logic [1023:0] RC0 = {
        128'ha458fea3f4933d7e_636920d871574e69,
        128'h0801f2e2858efc16_24a19947b3916cf7,
        128'hba7c9045f12c7f99_b8e1afed6a267e96,
        128'h2ffd72dbd01adfb7_d1310ba698dfb5ac,
        128'h9216d5d98979fb1b_3f84d5b5b5470917,
        128'hc0ac29b7c97c50dd_be5466cf34e90c6c,
        128'h452821e638d01377_082efa98ec4e6c89,
        128'ha4093822299f31d0_13198a2e03707344
    };
    localparam logic [1023:0] RC1 = {
        128'hb3ee1411636fbc2a_a15486af7c72e993,
        128'hb4cc5c341141e8ce_55ca396a2aab10b6,
        128'h5748986263e81440_e65525f3aa55ab94,
        128'h78af2fda55605c60_d71577c1bd314b27,
        128'h6c9e0e8bb01e8a3e_8e79dcb0603a180e,
        128'hca417918b8db38ef_c5d1b023286085f0,
        128'h9c30d5392af26013_7b54a41dc25a59b5,
        128'h718bcd5882154aee_0d95748f728eb658
    };

    // Nibble x of each table holds S[x] / S^-1[x].
    localparam logic [63:0] SBOX_TBL     = 64'h4d5e_0876_19ca_23fb;
    localparam logic [63:0] SBOX_INV_TBL = 64'h1ce5_046a_98df_237b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [BLK-1:0] rc0_lo(input int m);
        return RC0[128*m +: BLK];
    endfunction

    function automatic logic [BLK-1:0] rc1_lo(input int m);
        return RC1[128*m +: BLK];
    endfunction

    function automatic logic [BLK-1:0] sub_cells(input logic [BLK-1:0] x);
        logic [BLK-1:0] y;
        for (int i = 0; i < BLK/4; i++)
            y[4*i +: 4] = SBOX_TBL[{x[4*i +: 4], 2'b00} +: 4];
        return y;
    endfunction

    function automatic logic [BLK-1:0] sub_cells_inv(input logic [BLK-1:0] x);
        logic [BLK-1:0] y;
        for (int i = 0; i < BLK/4; i++)
            y[4*i +: 4] = SBOX_INV_TBL[{x[4*i +: 4], 2'b00} +: 4];
        return y;
    endfunction

    // Each 16-bit lane becomes the XOR of the other three lanes. This map is
    // its own inverse, which is what lets the decrypt schedule push keys
    // through it (M(a)^M(b) == M(a^b)).
    function automatic logic [BLK-1:0] mix_columns(input logic [BLK-1:0] x);
        return {x[47:0], x[63:48]} ^ {x[31:0], x[63:32]} ^ {x[15:0], x[63:16]};
    endfunction

    function automatic logic [BLK-1:0] mix_columns_add_key(input logic [BLK-1:0] x,
                                                          input logic [BLK-1:0] k);
        return mix_columns(x) ^ k;
    endfunction

    function automatic logic [BLK-1:0] round_fwd(input logic [BLK-1:0] s,
                                                input logic [BLK-1:0] k);
        return mix_columns(sub_cells(s)) ^ k;
    endfunction

    function automatic logic [BLK-1:0] round_inv(input logic [BLK-1:0] s,
                                                input logic [BLK-1:0] k);
        return sub_cells_inv(mix_columns(s) ^ k);
    endfunction

    // K1 is a sparse, strided pick of key bits that feeds the tweak hash.
    function automatic logic [K1_W-1:0] expand_k1(input logic [KEY_W-1:0] k0);
        logic [K1_W-1:0] k1;
        for (int i = 0; i < K1_W; i++)
            k1[i] = k0[(11*i) % KEY_W];
        return k1;
    endfunction

    // Returns {h1, h0}.
    function automatic logic [2*BLK-1:0] generate_tweakey(input logic [BLK-1:0]  t,
                                                          input logic [K1_W-1:0] k1);
        logic [BLK-1:0] h0;
        logic [BLK-1:0] h1;
        h0 = sub_cells(t ^ k1[63:0]) ^ k1[191:128];
        h1 = mix_columns(h0 ^ k1[127:64]) ^ {2'b00, k1[253:192]} ^ {t[31:0], t[63:32]};
        return {h1, h0};
    endfunction

endpackage

// File: rtl/blink_dec_iter_tk_sel.sv
// Decrypt tweakey schedule: picks the round key for the current round.
// Purely combinational.
//   rnd    in   4    current round number (1..13; other values give 0)
//   key_hi in  320   registered key chunks 2..6 (K0[447:128])
//   hash   in  128   registered tweak hash {h1, h0}
//   tk     out  64   round key for rnd
module blink_dec_tk_sel
    import blink_dec_iter_pkg::*;
(
    input  logic [3:0]         rnd,
    input  logic [KEY_W-1:129-1] key_hi,
    input  logic [2*BLK-1:0]   hash,
    output logic [BLK-1:0]     tk
);

    logic [BLK-1:0] h0, h1;
    logic [BLK-1:0] c2, c3, c4, c5, c6;
    logic [BLK-1:0] m_h0, m_h1, m_c2, m_c3, m_c4, m_c5, m_c6, m_rc;
    logic [BLK-1:0] rc0_sel;

    assign h0 = hash[BLK-1:0];
    assign h1 = hash[2*BLK-1:BLK];
    assign c2 = key_hi[191:128];
    assign c3 = key_hi[255:192];
    assign c4 = key_hi[319:256];
    assign c5 = key_hi[383:320];
    assign c6 = key_hi[447:384];

    assign m_h0 = mix_columns(h0);
    assign m_h1 = mix_columns(h1);
    assign m_c2 = mix_columns(c2);
    assign m_c3 = mix_columns(c3);
    assign m_c4 = mix_columns(c4);
    assign m_c5 = mix_columns(c5);
    assign m_c6 = mix_columns(c6);
    assign m_rc = mix_columns(rc0_sel);

    // Only one of the second-half rounds is active at a time, so a single
    // mixer serves all of the rc0 words.
    always_comb begin
        rc0_sel = '0;
        case (rnd)
            4'd8:    rc0_sel = rc0_lo(4);
            4'd9:    rc0_sel = rc0_lo(3);
            4'd10:   rc0_sel = rc0_lo(2);
            4'd12:   rc0_sel = rc0_lo(1);
            4'd13:   rc0_sel = rc0_lo(0);
            default: rc0_sel = '0;
        endcase
    end

    always_comb begin
        tk = '0;
        case (rnd)
            4'd1:    tk = c6 ^ rc1_lo(4);
            4'd2:    tk = c5 ^ rc1_lo(3);
            4'(R1):  tk = h1;
            4'd4:    tk = c4 ^ rc1_lo(2);
            4'd5:    tk = c3 ^ rc1_lo(1);
            4'd6:    tk = c2 ^ rc1_lo(0);
            4'd7:    tk = m_h0 ^ m_h1;
            4'd8:    tk = m_c6 ^ m_rc;
            4'd9:    tk = m_c5 ^ m_rc;
            4'd10:   tk = m_c4 ^ m_rc;
            4'd11:   tk = m_h0;
            4'd12:   tk = m_c3 ^ m_rc;
            4'd13:   tk = m_c2 ^ m_rc;
            default: tk = '0;
        endcase
    end

endmodule

// File: rtl/blink_dec_iter.sv
// Round-serial Blink-64 decryption engine, one round per clock.
//   clk       in    1   clock, rising edge
//   rst       in    1   synchronous active-high reset
//   in_valid  in    1   C/K0/T valid
//   in_ready  out   1   idle, will accept
//   C         in   64   ciphertext
//   K0        in  448   key
//   T         in   64   tweak
//   out_valid out   1   P valid
//   out_ready in    1   consumer accepts P
//   P         out  64   plaintext (registered)
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | one round per clock, rnd = 1..13
// DONE  | P valid, held until out_ready
module blink_dec_iter
    import blink_dec_iter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK-1:0]   C,
    input  logic [KEY_W-1:0] K0,
    input  logic [BLK-1:0]   T,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK-1:0]   P
);

    localparam logic [3:0] MID_RND  = 4'(ROUNDS / 2);
    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    state_t                 state;
    logic [3:0]             rnd;
    logic [BLK-1:0]         st;
    logic [BLK-1:0]         st_next;
    logic [BLK-1:0]         tk;
    // Chunk 1 is consumed at the accept edge, so only chunk 0 (output
    // whitening) and chunks 2..6 (schedule) are kept.
    logic [KEY_W-1:2*BLK]   key_hi;
    logic [BLK-1:0]         key_c0;
    logic [2*BLK-1:0]       hash;

    assign in_ready = (state == IDLE);

    blink_dec_tk_sel u_tk_sel (
        .rnd    (rnd),
        .key_hi (key_hi),
        .hash   (hash),
        .tk     (tk)
    );

    always_comb begin
        st_next = st;
        if (rnd < MID_RND)
            st_next = round_fwd(st, tk);
        else if (rnd == MID_RND)
            st_next = sub_cells(mix_columns_add_key(sub_cells(st), tk));
        else
            st_next = round_inv(st, tk);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            P         <= '0;
            rnd       <= '0;
            st        <= '0;
            key_hi    <= '0;
            key_c0    <= '0;
            hash      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        key_hi <= K0[KEY_W-1:2*BLK];
                        key_c0 <= K0[BLK-1:0];
                        hash   <= generate_tweakey(T, expand_k1(K0));
                        st     <= C ^ K0[2*BLK-1:BLK];
                        rnd    <= 4'd1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    st <= st_next;
                    if (rnd == LAST_RND) begin
                        P         <= st_next ^ key_c0;
                        out_valid <= 1'b1;
                        rnd       <= '0;
                        state     <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/blink_dec_iter.md
Name: blink_dec_iter

Overview:
- Round-serial Blink-64 decryption engine: recovers plaintext P from ciphertext C under a 448-bit key K0 and a 64-bit tweak T.
- Executes one round per clock; 13 compute cycles per block.
- Valid/ready handshake on both sides; sits behind the bus interface as the area-optimised decrypt path.
- Output is bit-exact with the team's combinational Blink_top driven with enc=0.

Parameters:
- ROUNDS, 14, total Blink rounds (fixed; not to be overridden).
- R1, 3, index of the hash-tweakey round.
- BLK, 64, block/tweak width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  C/K0/T valid.
- in_ready  out  1  engine idle and will accept.
- C  in  64  ciphertext.
- K0  in  448  key; chunk j = K0[64j+63:64j], j=0..6.
- T  in  64  tweak.
- out_valid  out  1  P valid.
- out_ready  in  1  consumer accepts P.
- P  out  64  plaintext (registered).

Behaviour:
- Reset: state=IDLE, out_valid=0, P=0, round counter rnd=0, all datapath and key registers 0. Reset has priority over every other event, including mid-RUN and DONE; any in-flight block is dropped.
- in_ready = (state==IDLE).
- IDLE: on in_valid & in_ready, capture K0 and hash={h1,h0}=generate_tweakey(T,K1), where K1[i]=K0[(11*i) mod 448] for i=0..253. Set st=C^chunk1, rnd=1, and move to RUN. Inputs may change freely after the accept edge.
- RUN, one operation per edge:
  - rnd 1..6: st=R(st, tk[rnd]).
  - rnd 7: st=SubCells(MixColumns_AddKey(SubCells(st), tk7)).
  - rnd 8..13: st=R_inv(st, tk[rnd]).
  - At the rnd=13 edge, P = result ^ chunk0, out_valid=1, state goes to DONE.
- Decrypt tweakey schedule. M = MixColumns. rc0[m]/rc1[m] = low 64 bits of 128-bit constant word m.
  - tk1=chunk6^rc1[4]
  - tk2=chunk5^rc1[3]
  - tk3=h1
  - tk4=chunk4^rc1[2]
  - tk5=chunk3^rc1[1]
  - tk6=chunk2^rc1[0]
  - tk7=M(h0)^M(h1)
  - tk8=M(chunk6)^M(rc0[4])
  - tk9=M(chunk5)^M(rc0[3])
  - tk10=M(chunk4)^M(rc0[2])
  - tk11=M(h0)
  - tk12=M(chunk3)^M(rc0[1])
  - tk13=M(chunk2)^M(rc0[0])
- DONE: P and out_valid held stable while out_ready=0. On out_valid & out_ready: out_valid=0, go to IDLE.
- Latency: accept at edge k, out_valid visible after edge k+13. Minimum block period 15 cycles when out_ready is tied high.
- in_valid during RUN/DONE is ignored; no queuing.
- out_ready during IDLE/RUN is ignored.

Decomposition:
- Shared header blink_const.vh: ROUNDS, R1, BLK, RC0/RC1 1024-bit constants, state encodings IDLE/RUN/DONE.
- Reuse the existing R, R_inv, SubCells, MixColumns, MixColumns_AddKey and generate_tweakey modules unchanged.
- One new sub-module, blink_dec_tk_sel: combinational. Inputs rnd, registered K0, registered hash. Output tk for the current round. Contains the eight M instances and the schedule mux.
- Top holds the FSM, counter, state register and output register.

Test Plan:
- K0=0, T=0, C = Blink_top(enc=1, P=0, K0=0, T=0) -> P=64'h0 with out_valid after exactly 13 cycles; in_ready=0 throughout.
- Random K0/T, C = Blink_top enc of P=64'h0123456789abcdef; 200 random vectors, each compared against Blink_top(enc=0) -> all match.
- Hold out_ready=0 for 20 cycles in DONE -> P and out_valid stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
- Change C/K0/T and pulse in_valid during RUN -> ignored; result equals the originally captured block.
- Assert rst at rnd=5 -> next cycle IDLE, out_valid=0, P=0; a new block then decrypts correctly.
- out_ready tied 1 with back-to-back in_valid -> accepts every 15 cycles; rst held high with in_valid=1 -> no accept.
